score_counter: RTL

Upstream of the game state machine: counts obstacles cleared during a run and produces the 7-bit `score` that the state machine compares against 99 to declare a win. Keeps a BCD copy of the score for the seven-segment decoder and a session high score that only reset clears. Sits between the obstacle/pipe logic, which pulses `obstacle_passed`, and the state machine, seven-segment decoder and LCD.

---
 rtl/score_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/score_counter.sv
// score_counter: counts obstacles cleared during a run. It keeps the binary
// score with a matching BCD copy and a session high score. Every output is a
// register. The high score is cleared only by reset.
module score_counter #(
    parameter int MAX_SCORE = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] game_state,
    input  logic       obstacle_passed,
    output logic [6:0] score,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       score_tick,
    output logic [6:0] high_score,
    output logic       new_high
);

    localparam logic [6:0] MAX_VAL = 7'(MAX_SCORE);
    localparam int         NUM_DIGITS = 2;

    // Decoded game state. Codes 4..7 fold into IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2,
        ST_WIN  = 2'd3
    } game_t;

    game_t                        state_now;
    game_t                        state_q_reg;
    logic                         obs_q_reg;
    logic [6:0]                   score_reg,  score_next;
    logic [NUM_DIGITS-1:0][3:0]   digit_reg,  digit_next;
    logic                         tick_reg,   tick_next;
    logic [6:0]                   high_reg,   high_next;
    logic                         new_high_reg, new_high_next;

    logic                         obs_rise;
    logic                         clear;
    logic                         inc;
    logic [NUM_DIGITS:0]          carry;

    // Map the raw 3-bit state code onto the four states this block cares about.
    always_comb begin
        state_now = ST_IDLE;
        case (game_state)
            3'd1:    state_now = ST_RUN;
            3'd2:    state_now = ST_OVER;
            3'd3:    state_now = ST_WIN;
            default: state_now = ST_IDLE;
        endcase
    end

    // A level held high counts once. Only its first high sample is an event.
    assign obs_rise = obstacle_passed && !obs_q_reg;
    // IDLE clears the score every cycle and wins over an increment.
    assign clear    = (state_now == ST_IDLE);
    // Only a live RUN cycle counts. Saturation blocks the increment and the tick.
    assign inc      = !clear && obs_rise && (state_now == ST_RUN) && (score_reg < MAX_VAL);

    // Binary score, score tick and high-score update.
    always_comb begin
        score_next    = score_reg;
        tick_next     = 1'b0;
        high_next     = high_reg;
        new_high_next = 1'b0;

        if (clear) begin
            score_next = '0;
        end else if (inc) begin
            score_next = score_reg + 7'd1;
            tick_next  = 1'b1;
        end

        // Leaving RUN compares the registered score. A strictly greater score
        // replaces the best. A tie keeps the old value and does not pulse.
        if ((state_q_reg == ST_RUN) && (state_now != ST_RUN) && (score_reg > high_reg)) begin
            high_next     = score_reg;
            new_high_next = 1'b1;
        end
    end

    // The BCD digits form a ripple chain. Each digit steps when the carry into
    // it is set, and a digit at 9 wraps to 0 and passes the carry on.
    assign carry[0] = inc;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign carry[gi+1] = carry[gi] && (digit_reg[gi] == 4'd9);

            // One BCD digit: clear, hold, or step with wrap at 9.
            always_comb begin
                digit_next[gi] = digit_reg[gi];
                if (clear) begin
                    digit_next[gi] = 4'd0;
                end else if (carry[gi]) begin
                    if (digit_reg[gi] == 4'd9) begin
                        digit_next[gi] = 4'd0;
                    end else begin
                        digit_next[gi] = digit_reg[gi] + 4'd1;
                    end
                end
            end
        end
    endgenerate

    // State register. Reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            obs_q_reg    <= 1'b0;
            state_q_reg  <= ST_IDLE;
            score_reg    <= '0;
            digit_reg    <= '0;
            tick_reg     <= 1'b0;
            high_reg     <= '0;
            new_high_reg <= 1'b0;
        end else begin
            obs_q_reg    <= obstacle_passed;
            state_q_reg  <= state_now;
            score_reg    <= score_next;
            digit_reg    <= digit_next;
            tick_reg     <= tick_next;
            high_reg     <= high_next;
            new_high_reg <= new_high_next;
        end
    end

    assign score      = score_reg;
    assign score_tens = digit_reg[1];
    assign score_ones = digit_reg[0];
    assign score_tick = tick_reg;
    assign high_score = high_reg;
    assign new_high   = new_high_reg;

endmodule
